sram_stream_reader: RTL and testbench
=====================================

Name: sram_stream_reader

Overview:
- Avalon-MM read master that fetches a contiguous block of words from the SRAM arbiter's test-runner slave port.
- Delivers the words in order on a valid/ready stream to the test runner's vector consumer.
- Tracks outstanding reads against buffer credit, so no returned word is ever dropped.
- Sits between the test-runner control logic and the arbiter's tr_* port.

Parameters:
- ADDR_WIDTH, 20, word address width (matches the arbiter).
- DATA_WIDTH, 16, word width.
- BE_WIDTH, DATA_WIDTH/8, byte-enable width.
- LEN_WIDTH, 16, transfer length counter width, in words.
- FIFO_DEPTH, 8, internal buffer depth; power of two, at least 2.
- MAX_OUTSTANDING, 4, maximum reads in flight; must be at most FIFO_DEPTH.

Ports:
- clock  in  1  single clock domain.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle pulse to begin a transfer; ignored while busy.
- base_addr  in  ADDR_WIDTH  first word address, sampled on start.
- length  in  LEN_WIDTH  number of words, sampled on start.
- abort  in  1  stop the transfer and discard its data.
- busy  out  1  transfer in progress.
- done  out  1  one-cycle pulse at transfer completion or after abort.
- err  out  1  sticky flag: a response arrived with nothing outstanding; cleared on start.
- av_address  out  ADDR_WIDTH  read address.
- av_byteenable  out  BE_WIDTH  constant all ones.
- av_read  out  1  read request.
- av_waitrequest  in  1  slave stall.
- av_readdata  in  DATA_WIDTH  response data.
- av_readdataready  in  1  response valid.
- out_data  out  DATA_WIDTH  stream data.
- out_valid  out  1  stream valid.
- out_ready  in  1  consumer ready.

Behaviour:
- Reset values:
  - busy, done, err, av_read, out_valid = 0.
  - av_address = 0; av_byteenable = all ones.
  - FIFO empty; all counters 0; state IDLE.
- States: IDLE, ISSUE, DRAIN, FLUSH.
- IDLE:
  - start with length != 0: latch the address and remaining count, clear err, go to ISSUE; busy rises the next cycle.
  - start with length == 0: done pulses the next cycle; stay in IDLE; busy stays 0.
- ISSUE, request rule:
  - av_read = 1 when remaining > 0, outstanding < MAX_OUTSTANDING, and outstanding + fifo_count < FIFO_DEPTH.
- ISSUE, acceptance:
  - A request is accepted when av_read = 1 and av_waitrequest = 0.
  - On acceptance: address increments by 1, remaining decrements, outstanding increments.
  - While av_waitrequest = 1, av_read and av_address are held stable.
  - Credit cannot shrink during a stall, so av_read never drops except on abort.
- Address wraps from 2^ADDR_WIDTH-1 to 0.
- Zero-wait throughput: one accepted read per cycle.
- Responses:
  - On av_readdataready, push av_readdata into the FIFO and decrement outstanding.
  - Acceptance and response in the same cycle leave outstanding unchanged.
  - Response latency is variable, at least 1 cycle; order is preserved.
- Spurious response (av_readdataready with outstanding == 0): data discarded, err set, counters unchanged.
- Stream output:
  - out_valid = FIFO not empty; out_data = FIFO head.
  - Pop on out_valid && out_ready.
  - Push and pop in the same cycle are both legal, including when the FIFO is full (because of credit) or empty (pass-through is not required; one cycle minimum latency from response to out_valid).
- ISSUE to DRAIN when remaining == 0.
- DRAIN:
  - Done when outstanding == 0 and the FIFO is empty.
  - On that condition: done = 1 for one cycle, busy = 0 in the same cycle, return to IDLE.
- Abort:
  - Abort in ISSUE or DRAIN drops av_read the next cycle; an unaccepted request is withdrawn, which the arbiter tolerates since it registers only on acceptance.
  - Go to FLUSH: the FIFO is cleared, responses still outstanding are counted down and discarded, and out_valid = 0.
  - When outstanding == 0: done pulses, return to IDLE.
  - Abort in IDLE is ignored.
- start while busy is ignored, including during FLUSH.
- Reset mid-transfer clears everything immediately; outstanding responses arriving after reset release are flagged as spurious (err).

Decomposition:
- Shared package: state encoding for IDLE/ISSUE/DRAIN/FLUSH and the all-ones byte-enable constant.
- One sub-module: sync_fifo.
  - Parameters: width, depth.
  - Ports: push, pop, flush, full, empty, count.
  - Registered read pointer; count is $clog2(DEPTH)+1 bits wide.

Test Plan:
- base_addr=0x00100, length=5, waitrequest=0, slave latency 2, out_ready=1 -> reads issued on 5 consecutive cycles at 0x00100..0x00104; stream emits data in address order; done pulses once; busy deasserts with done.
- Same transfer with waitrequest high for 3 cycles on the second read -> av_read and av_address=0x00101 held stable for all 4 cycles; exactly 5 acceptances; no duplicate or lost word.
- length=20, out_ready=0 -> requests stop after FIFO_DEPTH (8) acceptances and outstanding+fifo_count never exceeds 8; raising out_ready lets all 20 words arrive in order.
- base_addr=0xFFFFE, length=4 -> addresses 0xFFFFE, 0xFFFFF, 0x00000, 0x00001.
- Abort in the cycle after the 3rd acceptance, with 2 responses outstanding -> av_read low the next cycle; out_valid stays 0; 2 late responses discarded; done pulses; a following start with length=1 works cleanly with err=0.
- length=0 start -> done the next cycle, av_read never asserted. Spurious av_readdataready in IDLE -> err=1, no stream output.

Source files
------------

// File: rtl/sram_stream_reader_pkg.sv
// Shared types and constants for the SRAM stream reader.
package sram_stream_reader_pkg;

    localparam int unsigned DefAddrWidth      = 20;
    localparam int unsigned DefDataWidth      = 16;
    localparam int unsigned DefBeWidth        = DefDataWidth / 8;
    localparam int unsigned DefLenWidth       = 16;
    localparam int unsigned DefFifoDepth      = 8;
    localparam int unsigned DefMaxOutstanding = 4;

    // Every read fetches the full word.
    localparam logic [DefBeWidth-1:0] BeAllOnes = {DefBeWidth{1'b1}};

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StDrain,
        StFlush
    } state_e;

endpackage

// File: rtl/sram_stream_reader_if.sv
// Avalon-MM read bus plus the outgoing valid/ready word stream.
interface sram_stream_reader_if
    import sram_stream_reader_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DefAddrWidth,
    parameter int unsigned DATA_WIDTH = DefDataWidth,
    parameter int unsigned BE_WIDTH   = DATA_WIDTH / 8
);

    logic [ADDR_WIDTH-1:0] av_address;
    logic [BE_WIDTH-1:0]   av_byteenable;
    logic                  av_read;
    logic                  av_waitrequest;
    logic [DATA_WIDTH-1:0] av_readdata;
    logic                  av_readdataready;

    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;

    // Reader side: drives the read requests and the stream.
    modport master (
        output av_address,
        output av_byteenable,
        output av_read,
        input  av_waitrequest,
        input  av_readdata,
        input  av_readdataready,
        output out_data,
        output out_valid,
        input  out_ready
    );

    // Arbiter slave port and stream consumer side.
    modport slave (
        input  av_address,
        input  av_byteenable,
        input  av_read,
        output av_waitrequest,
        output av_readdata,
        output av_readdataready,
        input  out_data,
        input  out_valid,
        output out_ready
    );

endinterface

// File: rtl/sram_stream_reader_sync_fifo.sv
// Single-clock FIFO with synchronous flush; head word read from the registered read pointer.
module sram_stream_reader_sync_fifo #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]  count_q;
    logic             do_push, do_pop;

    // Push while full is legal when a pop frees the slot in the same cycle.
    always_comb begin
        full_o  = (count_q == CntW'(DEPTH));
        empty_o = (count_q == '0);
        do_push = push_i && (!full_o || pop_i);
        do_pop  = pop_i && !empty_o;
        data_o  = mem_q[rd_ptr_q];
        count_o = count_q;
    end

    // Storage array, no reset needed.
    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    // Pointer and occupancy tracking; flush discards everything held.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CntW'(1);
                2'b01:   count_q <= count_q - CntW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/sram_stream_reader.sv
// Avalon-MM block read master that streams the fetched words out in order.
module sram_stream_reader
    import sram_stream_reader_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH      = DefAddrWidth,
    parameter int unsigned DATA_WIDTH      = DefDataWidth,
    parameter int unsigned BE_WIDTH        = DATA_WIDTH / 8,
    parameter int unsigned LEN_WIDTH       = DefLenWidth,
    parameter int unsigned FIFO_DEPTH      = DefFifoDepth,
    parameter int unsigned MAX_OUTSTANDING = DefMaxOutstanding
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   start_i,
    input  logic [ADDR_WIDTH-1:0]  base_addr_i,
    input  logic [LEN_WIDTH-1:0]   length_i,
    input  logic                   abort_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   err_o,
    sram_stream_reader_if.master   bus_io
);

    localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned CrW  = CntW + 1;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LEN_WIDTH-1:0]  remaining_q, remaining_d;
    logic [CntW-1:0]       outstanding_q, outstanding_d;
    logic                  err_q, err_d;
    logic                  done_q, done_d;

    logic [DATA_WIDTH-1:0] fifo_data;
    logic [CntW-1:0]       fifo_count;
    logic                  fifo_full, fifo_empty;
    logic [CrW-1:0]        credit_used;
    logic                  len_zero, active, req, accept;
    logic                  rsp_valid, rsp_spurious, push, pop, flush;

    assign len_zero = (length_i == '0);

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= StIdle;
        else       state_q <= state_d;
    end

    // Next state; done is registered so it lands in the cycle busy drops.
    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    if (len_zero) done_d  = 1'b1;
                    else          state_d = StIssue;
                end
            end
            StIssue: begin
                if (abort_i)                 state_d = StFlush;
                else if (remaining_q == '0)  state_d = StDrain;
            end
            StDrain: begin
                if (abort_i) begin
                    state_d = StFlush;
                end else if (outstanding_q == '0 && fifo_empty) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            StFlush: begin
                if (outstanding_q == '0) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Request, response and stream control decoded from state and counters.
    always_comb begin
        active       = (state_q == StIssue) || (state_q == StDrain);
        busy_o       = (state_q != StIdle);
        // Reads in flight plus words held must never exceed the buffer.
        credit_used  = {1'b0, outstanding_q} + {1'b0, fifo_count};
        req          = (state_q == StIssue) && (remaining_q != '0) &&
                       (outstanding_q < CntW'(MAX_OUTSTANDING)) &&
                       (credit_used < CrW'(FIFO_DEPTH));
        accept       = req && !bus_io.av_waitrequest;
        rsp_valid    = bus_io.av_readdataready && (outstanding_q != '0);
        rsp_spurious = bus_io.av_readdataready && (outstanding_q == '0);
        push         = rsp_valid && active;
        flush        = (state_q == StFlush) || (abort_i && active);
        pop          = !fifo_empty && bus_io.out_ready;
    end

    // Address, remaining and outstanding bookkeeping.
    always_comb begin
        addr_d        = addr_q;
        remaining_d   = remaining_q;
        outstanding_d = outstanding_q;
        err_d         = err_q;
        if (start_i && state_q == StIdle) begin
            err_d = 1'b0;
            if (!len_zero) begin
                addr_d      = base_addr_i;
                remaining_d = length_i;
            end
        end else if (accept) begin
            addr_d      = addr_q + ADDR_WIDTH'(1);
            remaining_d = remaining_q - LEN_WIDTH'(1);
        end
        case ({accept, rsp_valid})
            2'b10:   outstanding_d = outstanding_q + CntW'(1);
            2'b01:   outstanding_d = outstanding_q - CntW'(1);
            default: outstanding_d = outstanding_q;
        endcase
        if (rsp_spurious) err_d = 1'b1;
    end

    // Datapath registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            addr_q        <= '0;
            remaining_q   <= '0;
            outstanding_q <= '0;
            err_q         <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            addr_q        <= addr_d;
            remaining_q   <= remaining_d;
            outstanding_q <= outstanding_d;
            err_q         <= err_d;
            done_q        <= done_d;
        end
    end

    sram_stream_reader_sync_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .data_i  (bus_io.av_readdata),
        .pop_i   (pop),
        .flush_i (flush),
        .data_o  (fifo_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign done_o               = done_q;
    assign err_o                = err_q;
    assign bus_io.av_address    = addr_q;
    assign bus_io.av_byteenable = {BE_WIDTH{1'b1}};
    assign bus_io.av_read       = req;
    assign bus_io.out_valid     = !fifo_empty;
    assign bus_io.out_data      = fifo_data;

    // Credit accounting keeps the FIFO from overflowing; full is informational only.
    logic unused_full;
    assign unused_full = fifo_full;

endmodule

// File: tb/tb_sram_stream_reader.sv
// Directed bench: Avalon slave model with configurable latency/stall and a stream scoreboard.
module tb_sram_stream_reader;
    import sram_stream_reader_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, abort;
    logic [19:0] base;
    logic [15:0] len;
    logic        busy, done, err;

    int checks = 0;
    int errors = 0;

    sram_stream_reader_if #(.ADDR_WIDTH(20), .DATA_WIDTH(16), .BE_WIDTH(2)) bus ();

    sram_stream_reader #(
        .ADDR_WIDTH      (20),
        .DATA_WIDTH      (16),
        .BE_WIDTH        (2),
        .LEN_WIDTH       (16),
        .FIFO_DEPTH      (8),
        .MAX_OUTSTANDING (4)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (start),
        .base_addr_i (base),
        .length_i    (len),
        .abort_i     (abort),
        .busy_o      (busy),
        .done_o      (done),
        .err_o       (err),
        .bus_io      (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] model(input logic [19:0] a);
        return a[15:0] ^ 16'h5A5A;
    endfunction

    // Slave model state
    typedef struct {
        int          due;
        logic [15:0] data;
    } rsp_t;

    int          cyc = 0;
    int          lat = 2;
    int          acc_total = 0;
    int          stall_at = -1;
    int          stall_len = 0;
    int          stall_seen = 0;
    int          spur_req = 0;
    int          spur_done = 0;
    logic [19:0] acc_addr_q[$];
    int          acc_cyc_q[$];
    logic [19:0] stall_addr_q[$];
    rsp_t        rsp_q[$];

    // Stream monitor state
    logic [15:0] rx_q[$];
    int          done_cnt = 0;
    int          valid_cyc = 0;
    int          read_cyc = 0;
    int          bad_done_busy = 0;

    assign bus.av_waitrequest = bus.av_read && (acc_total == stall_at) && (stall_seen < stall_len);

    always @(posedge clk) begin : slave
        rsp_t e;
        bus.av_readdataready <= 1'b0;
        bus.av_readdata      <= 16'h0000;
        if (bus.av_read && bus.av_waitrequest) begin
            stall_seen <= stall_seen + 1;
            stall_addr_q.push_back(bus.av_address);
        end else if (bus.av_read) begin
            acc_total  <= acc_total + 1;
            stall_seen <= 0;
            acc_addr_q.push_back(bus.av_address);
            acc_cyc_q.push_back(cyc);
            e.due  = cyc + lat - 1;
            e.data = model(bus.av_address);
            rsp_q.push_back(e);
        end
        if (rsp_q.size() > 0 && rsp_q[0].due == cyc) begin
            bus.av_readdataready <= 1'b1;
            bus.av_readdata      <= rsp_q[0].data;
            void'(rsp_q.pop_front());
        end else if (spur_req != spur_done) begin
            bus.av_readdataready <= 1'b1;
            bus.av_readdata      <= 16'hDEAD;
            spur_done            <= spur_done + 1;
        end
        cyc <= cyc + 1;
    end

    always @(posedge clk) begin : monitor
        if (bus.out_valid && bus.out_ready) rx_q.push_back(bus.out_data);
        if (done) done_cnt <= done_cnt + 1;
        if (done && busy) bad_done_busy <= bad_done_busy + 1;
        if (bus.out_valid) valid_cyc <= valid_cyc + 1;
        if (bus.av_read) read_cyc <= read_cyc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_start(input logic [19:0] b, input logic [15:0] l);
        start = 1'b1;
        base  = b;
        len   = l;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int d0;
        d0 = done_cnt;
        for (int i = 0; i < budget && done_cnt == d0; i++) @(negedge clk);
        chk({tag, "_done_seen"}, 32'(done_cnt != d0), 32'd1);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        int a0, r0, d0, s0, v0, off, maxc, bad;
        rst = 1'b1; start = 1'b0; abort = 1'b0; base = '0; len = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_busy",  32'(busy), 32'd0);
        chk("rst_done",  32'(done), 32'd0);
        chk("rst_err",   32'(err), 32'd0);
        chk("rst_read",  32'(bus.av_read), 32'd0);
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_addr",  32'(bus.av_address), 32'd0);
        chk("rst_be",    32'(bus.av_byteenable), 32'(BeAllOnes));
        rst = 1'b0;
        @(negedge clk);

        // Basic 5-word transfer, zero wait, latency 2
        lat = 2; a0 = acc_total; r0 = rx_q.size(); d0 = done_cnt;
        do_start(20'h00100, 16'd5);
        chk("t1_busy", 32'(busy), 32'd1);
        wait_done("t1", 60);
        chk("t1_busy_low", 32'(busy), 32'd0);
        chk("t1_nacc", 32'(acc_total - a0), 32'd5);
        for (int i = 0; i < 5; i++) chk("t1_addr", 32'(acc_addr_q[a0+i]), 32'h100 + 32'(i));
        chk("t1_b2b", 32'(acc_cyc_q[a0+4] - acc_cyc_q[a0]), 32'd4);
        chk("t1_nrx", 32'(rx_q.size() - r0), 32'd5);
        chk("t1_first", 32'(rx_q[r0]), 32'h5B5A);
        chk("t1_last", 32'(rx_q[r0+4]), 32'h5B5E);
        for (int i = 0; i < 5; i++) chk("t1_data", 32'(rx_q[r0+i]), 32'(model(20'h100 + 20'(i))));
        repeat (3) @(negedge clk);
        chk("t1_one_done", 32'(done_cnt - d0), 32'd1);

        // Stall the second read for 3 cycles
        a0 = acc_total; r0 = rx_q.size(); s0 = stall_addr_q.size();
        stall_at = acc_total + 1; stall_len = 3;
        do_start(20'h00100, 16'd5);
        wait_done("t2", 60);
        chk("t2_nstall", 32'(stall_addr_q.size() - s0), 32'd3);
        for (int i = 0; i < 3; i++) chk("t2_stall_addr", 32'(stall_addr_q[s0+i]), 32'h101);
        chk("t2_nacc", 32'(acc_total - a0), 32'd5);
        chk("t2_acc1", 32'(acc_addr_q[a0+1]), 32'h101);
        chk("t2_nrx", 32'(rx_q.size() - r0), 32'd5);
        bad = 0;
        for (int i = 0; i < 5; i++) if (rx_q[r0+i] !== model(20'h100 + 20'(i))) bad++;
        chk("t2_order", 32'(bad), 32'd0);
        stall_at = -1;

        // Backpressure: credit stops requests at FIFO depth
        a0 = acc_total; r0 = rx_q.size(); off = acc_total - rx_q.size(); maxc = 0;
        bus.out_ready = 1'b0;
        do_start(20'h00200, 16'd20);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (acc_total - rx_q.size() - off > maxc) maxc = acc_total - rx_q.size() - off;
        end
        chk("t3_nacc_stalled", 32'(acc_total - a0), 32'd8);
        chk("t3_nrx_stalled", 32'(rx_q.size() - r0), 32'd0);
        bus.out_ready = 1'b1;
        d0 = done_cnt;
        for (int i = 0; i < 200 && done_cnt == d0; i++) begin
            @(negedge clk);
            if (acc_total - rx_q.size() - off > maxc) maxc = acc_total - rx_q.size() - off;
        end
        chk("t3_done_seen", 32'(done_cnt - d0), 32'd1);
        chk("t3_max_credit", 32'(maxc), 32'd8);
        chk("t3_nrx", 32'(rx_q.size() - r0), 32'd20);
        bad = 0;
        for (int i = 0; i < 20; i++) if (rx_q[r0+i] !== model(20'h200 + 20'(i))) bad++;
        chk("t3_order", 32'(bad), 32'd0);

        // Address wrap
        a0 = acc_total; r0 = rx_q.size();
        do_start(20'hFFFFE, 16'd4);
        wait_done("t4", 60);
        chk("t4_addr0", 32'(acc_addr_q[a0]),   32'hFFFFE);
        chk("t4_addr1", 32'(acc_addr_q[a0+1]), 32'hFFFFF);
        chk("t4_addr2", 32'(acc_addr_q[a0+2]), 32'h00000);
        chk("t4_addr3", 32'(acc_addr_q[a0+3]), 32'h00001);
        chk("t4_data0", 32'(rx_q[r0]),   32'hA5A4);
        chk("t4_data2", 32'(rx_q[r0+2]), 32'h5A5A);

        // Abort after the 3rd acceptance; the 4th request is stalled and withdrawn
        lat = 3; a0 = acc_total; r0 = rx_q.size(); v0 = valid_cyc;
        stall_at = acc_total + 3; stall_len = 1000;
        do_start(20'h00400, 16'd6);
        for (int i = 0; i < 20 && acc_total != a0 + 3; i++) @(negedge clk);
        chk("t5_three_acc", 32'(acc_total - a0), 32'd3);
        chk("t5_req_pending", 32'(bus.av_read), 32'd1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("t5_read_dropped", 32'(bus.av_read), 32'd0);
        chk("t5_busy_flush", 32'(busy), 32'd1);
        wait_done("t5", 40);
        chk("t5_nacc", 32'(acc_total - a0), 32'd3);
        chk("t5_nrx", 32'(rx_q.size() - r0), 32'd0);
        chk("t5_no_valid", 32'(valid_cyc - v0), 32'd0);
        chk("t5_err", 32'(err), 32'd0);
        stall_at = -1; stall_len = 0; lat = 2;
        r0 = rx_q.size();
        do_start(20'h00300, 16'd1);
        wait_done("t5b", 40);
        chk("t5b_nrx", 32'(rx_q.size() - r0), 32'd1);
        chk("t5b_data", 32'(rx_q[r0]), 32'h595A);
        chk("t5b_err", 32'(err), 32'd0);

        // Zero length, then a spurious response while idle
        d0 = done_cnt; s0 = read_cyc;
        do_start(20'h00600, 16'd0);
        chk("t6_done", 32'(done), 32'd1);
        chk("t6_busy", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        chk("t6_no_read", 32'(read_cyc - s0), 32'd0);
        chk("t6_one_done", 32'(done_cnt - d0), 32'd1);
        r0 = rx_q.size(); v0 = valid_cyc;
        spur_req = spur_req + 1;
        repeat (4) @(negedge clk);
        chk("t6_spur_err", 32'(err), 32'd1);
        chk("t6_spur_nrx", 32'(rx_q.size() - r0), 32'd0);
        chk("t6_spur_valid", 32'(valid_cyc - v0), 32'd0);
        do_start(20'h00500, 16'd1);
        chk("t6_err_cleared", 32'(err), 32'd0);
        wait_done("t6b", 40);
        chk("t6b_data", 32'(rx_q[r0]), 32'h5F5A);

        chk("done_with_busy", 32'(bad_done_busy), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
